// File: rtl/data_mem_sized.sv
// data_mem_sized: byte-addressed, little-endian data memory for the load/store
// stage. Sized loads/stores with sign/zero extension, valid/ready request and
// registered response, alignment/range/size error reporting, and a row-by-row
// clear sweep after reset.
module data_mem_sized #(
    parameter int XLEN        = 64,
    parameter int DEPTH_BYTES = 8192,
    parameter int ADDR_W      = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err
);

    localparam int BYTES = XLEN / 8;
    localparam int ROWS  = DEPTH_BYTES / BYTES;
    localparam int OFF_W = $clog2(BYTES);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_RESP
    } state_t;

    state_t           state;
    logic [ROW_W-1:0] clr_cnt;

    // The array is organised as BYTES-wide rows; an aligned access of at most
    // BYTES bytes never straddles two rows.
    logic [XLEN-1:0]  mem [ROWS];

    logic [3:0]        nbytes;
    logic [OFF_W-1:0]  off;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W:0]   end_addr;
    logic              misaligned;
    logic              out_of_range;
    logic              bad_size;
    logic              req_err;
    logic              accept;
    logic [XLEN-1:0]   row_data;
    logic [XLEN-1:0]   lane;
    logic              sign_bit;
    logic [XLEN-1:0]   load_data;
    logic [XLEN-1:0]   wdata_sh;
    logic [BYTES-1:0]  byte_en;

    // Request decode: size, position within the row and error conditions.
    always_comb begin
        nbytes       = 4'd1 << req_size;
        off          = req_addr[OFF_W-1:0];
        row          = req_addr[OFF_W +: ROW_W];
        misaligned   = (req_addr[2:0] & 3'(nbytes - 4'd1)) != 3'd0;
        // Widened by one bit so addresses near the top of the space cannot wrap.
        end_addr     = {1'b0, req_addr} + (ADDR_W+1)'(nbytes);
        out_of_range = end_addr > (ADDR_W+1)'(DEPTH_BYTES);
        bad_size     = (XLEN == 32) && (req_size == 2'd3);
        req_err      = misaligned || out_of_range || bad_size;
        accept       = req_valid && req_ready;
    end

    // Load path: select the addressed lane and extend it to XLEN.
    always_comb begin
        row_data = mem[row];
        lane     = row_data >> {off, 3'b000};
        case (req_size)
            2'd0:    sign_bit = lane[7];
            2'd1:    sign_bit = lane[15];
            2'd2:    sign_bit = lane[31];
            default: sign_bit = lane[XLEN-1];
        endcase
        load_data = '0;
        for (int i = 0; i < XLEN; i++) begin
            if (i < int'(nbytes) * 8) begin
                load_data[i] = lane[i];
            end else begin
                load_data[i] = sign_bit && !req_unsigned;
            end
        end
    end

    // Store path: move the store data to its byte offset and build byte enables.
    always_comb begin
        wdata_sh = req_wdata << {off, 3'b000};
        byte_en  = '0;
        for (int b = 0; b < BYTES; b++) begin
            byte_en[b] = (b >= int'(off)) && (b < int'(off) + int'(nbytes));
        end
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_INIT;
            clr_cnt   <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (clr_cnt == LAST_ROW) begin
                        state     <= ST_IDLE;
                        clr_cnt   <= '0;
                        req_ready <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (accept) begin
                        state     <= ST_RESP;
                        req_ready <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_err   <= req_err;
                        rsp_rdata <= (req_we || req_err) ? '0 : load_data;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state     <= ST_IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_INIT;
                    clr_cnt   <= '0;
                    req_ready <= 1'b0;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    // Array writes: one cleared row per cycle during INIT, byte-enabled stores otherwise.
    // NOTE: the array has no reset branch; clearing it in one cycle would need a
    // reset on every bit, so the INIT sweep clears it one row per cycle instead.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == ST_INIT) begin
                mem[clr_cnt] <= '0;
            end else if (accept && req_we && !req_err) begin
                for (int b = 0; b < BYTES; b++) begin
                    if (byte_en[b]) begin
                        mem[row][8*b +: 8] <= wdata_sh[8*b +: 8];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_data_mem_sized.sv
// Directed testbench for data_mem_sized: default 64-bit instance plus a small
// 32-bit instance for the illegal double-size case.
module tb_data_mem_sized;

    logic        clk;
    logic        rst;

    // 64-bit instance
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [63:0] rsp_rdata;
    logic        rsp_err;

    // 32-bit instance
    logic        req_valid_b;
    logic        req_ready_b;
    logic        req_we_b;
    logic [1:0]  req_size_b;
    logic        req_unsigned_b;
    logic [31:0] req_addr_b;
    logic [31:0] req_wdata_b;
    logic        rsp_valid_b;
    logic        rsp_ready_b;
    logic [31:0] rsp_rdata_b;
    logic        rsp_err_b;

    int checks = 0;
    int errors = 0;

    data_mem_sized dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err)
    );

    data_mem_sized #(.XLEN(32), .DEPTH_BYTES(64), .ADDR_W(32)) dut_b (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid_b),
        .req_ready    (req_ready_b),
        .req_we       (req_we_b),
        .req_size     (req_size_b),
        .req_unsigned (req_unsigned_b),
        .req_addr     (req_addr_b),
        .req_wdata    (req_wdata_b),
        .rsp_valid    (rsp_valid_b),
        .rsp_ready    (rsp_ready_b),
        .rsp_rdata    (rsp_rdata_b),
        .rsp_err      (rsp_err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Count cycles from reset release until req_ready rises.
    task automatic wait_sweep(input string tag, input int exp_cycles);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!req_ready && n < 3000);
        check(tag, 64'(n), 64'(exp_cycles));
    endtask

    // One request on the 64-bit instance with rsp_ready held high.
    task automatic req64(input logic we, input logic [1:0] size, input logic uns,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         output logic [63:0] rdata, output logic err);
        int n = 0;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        while (!req_ready && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("req_ready_wait", {63'd0, req_ready}, 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rsp_valid_after_accept", {63'd0, rsp_valid}, 64'd1);
        rdata = rsp_rdata;
        err   = rsp_err;
        @(posedge clk);
        #1;
    endtask

    task automatic load64(input string tag, input logic [1:0] size, input logic uns,
                          input logic [63:0] addr, input logic [63:0] exp_data,
                          input logic exp_err);
        logic [63:0] d;
        logic        e;
        req64(1'b0, size, uns, addr, 64'd0, d, e);
        check({tag, "_data"}, d, exp_data);
        check({tag, "_err"}, {63'd0, e}, {63'd0, exp_err});
    endtask

    task automatic store64(input string tag, input logic [1:0] size, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic exp_err);
        logic [63:0] d;
        logic        e;
        req64(1'b1, size, 1'b0, addr, wdata, d, e);
        check({tag, "_data"}, d, 64'd0);
        check({tag, "_err"}, {63'd0, e}, {63'd0, exp_err});
    endtask

    // One request on the 32-bit instance, checking data and error.
    task automatic req32(input string tag, input logic we, input logic [1:0] size,
                         input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_data, input logic exp_err);
        int n = 0;
        req_we_b       = we;
        req_size_b     = size;
        req_unsigned_b = uns;
        req_addr_b     = addr;
        req_wdata_b    = wdata;
        req_valid_b    = 1'b1;
        while (!req_ready_b && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_ready_wait"}, {63'd0, req_ready_b}, 64'd1);
        @(posedge clk);
        #1;
        req_valid_b = 1'b0;
        check({tag, "_valid"}, {63'd0, rsp_valid_b}, 64'd1);
        check({tag, "_data"}, {32'd0, rsp_rdata_b}, {32'd0, exp_data});
        check({tag, "_err"}, {63'd0, rsp_err_b}, {63'd0, exp_err});
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [63:0] held;

        rst            = 1'b1;
        req_valid      = 1'b0;
        req_we         = 1'b0;
        req_size       = 2'd0;
        req_unsigned   = 1'b0;
        req_addr       = '0;
        req_wdata      = '0;
        rsp_ready      = 1'b1;
        req_valid_b    = 1'b0;
        req_we_b       = 1'b0;
        req_size_b     = 2'd0;
        req_unsigned_b = 1'b0;
        req_addr_b     = '0;
        req_wdata_b    = '0;
        rsp_ready_b    = 1'b1;

        // Reset pulse of 3 cycles
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", {63'd0, req_ready}, 64'd0);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_rsp_rdata", rsp_rdata, 64'd0);
        check("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
        rst = 1'b0;
        wait_sweep("sweep_cycles", 1024);

        load64("top_double", 2'd3, 1'b0, 64'h1FF8, 64'd0, 1'b0);

        // Sized stores and loads
        store64("st_double_10", 2'd3, 64'h10, 64'h0C3C3EAAF00FCC33, 1'b0);
        load64("ld_b10_s", 2'd0, 1'b0, 64'h10, 64'h0000000000000033, 1'b0);
        load64("ld_b13_s", 2'd0, 1'b0, 64'h13, 64'hFFFFFFFFFFFFFFF0, 1'b0);
        load64("ld_b13_u", 2'd0, 1'b1, 64'h13, 64'h00000000000000F0, 1'b0);
        load64("ld_h12_u", 2'd1, 1'b1, 64'h12, 64'h000000000000F00F, 1'b0);
        load64("ld_h12_s", 2'd1, 1'b0, 64'h12, 64'hFFFFFFFFFFFFF00F, 1'b0);
        load64("ld_w14_s", 2'd2, 1'b0, 64'h14, 64'h000000000C3C3EAA, 1'b0);
        load64("ld_w10_s", 2'd2, 1'b0, 64'h10, 64'hFFFFFFFFF00FCC33, 1'b0);

        // Partial store
        store64("st_half_12", 2'd1, 64'h12, 64'h000000000000BEEF, 1'b0);
        load64("ld_d10_after_half", 2'd3, 1'b0, 64'h10, 64'h0C3C3EAABEEFCC33, 1'b0);

        // Errors
        store64("st_double_20", 2'd3, 64'h20, 64'h1122334455667788, 1'b0);
        store64("st_word_21_misaligned", 2'd2, 64'h21, 64'hFFFFFFFFFFFFFFFF, 1'b1);
        load64("ld_d20_unchanged", 2'd3, 1'b0, 64'h20, 64'h1122334455667788, 1'b0);
        load64("ld_d1ffc_err", 2'd3, 1'b0, 64'h1FFC, 64'd0, 1'b1);
        load64("ld_w1ffc_ok", 2'd2, 1'b1, 64'h1FFC, 64'd0, 1'b0);
        load64("ld_d2000_range", 2'd3, 1'b0, 64'h2000, 64'd0, 1'b1);
        load64("ld_d_top_nowrap", 2'd3, 1'b0, 64'hFFFFFFFFFFFFFFF8, 64'd0, 1'b1);
        store64("st_d2000_range", 2'd3, 64'h2000, 64'hAAAAAAAAAAAAAAAA, 1'b1);

        // Back-pressure: hold rsp_ready low for 5 cycles after a load
        rsp_ready    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd3;
        req_unsigned = 1'b0;
        req_addr     = 64'h10;
        req_wdata    = 64'd0;
        req_valid    = 1'b1;
        check("bp_ready_before", {63'd0, req_ready}, 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        held = 64'h0C3C3EAABEEFCC33;
        for (int k = 0; k < 5; k++) begin
            check("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            check("bp_rsp_rdata", rsp_rdata, held);
            check("bp_req_ready", {63'd0, req_ready}, 64'd0);
            if (k == 1) begin
                // A store offered while the response is pending must be ignored.
                req_we    = 1'b1;
                req_size  = 2'd0;
                req_addr  = 64'h10;
                req_wdata = 64'h55;
                req_valid = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        req_we    = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", {63'd0, rsp_valid}, 64'd0);
        check("bp_release_ready", {63'd0, req_ready}, 64'd1);
        check("bp_rdata_kept", rsp_rdata, held);
        load64("bp_store_ignored", 2'd0, 1'b1, 64'h10, 64'h33, 1'b0);

        // Reset while a response is pending
        store64("st_double_40", 2'd3, 64'h40, 64'hDEADBEEFCAFEF00D, 1'b0);
        rsp_ready    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd3;
        req_unsigned = 1'b0;
        req_addr     = 64'h40;
        req_valid    = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("mid_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check("mid_rsp_rdata", rsp_rdata, 64'hDEADBEEFCAFEF00D);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_valid", {63'd0, rsp_valid}, 64'd0);
        check("mid_rst_ready", {63'd0, req_ready}, 64'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        rsp_ready = 1'b1;
        wait_sweep("resweep_cycles", 1024);
        load64("ld_d40_cleared", 2'd3, 1'b0, 64'h40, 64'd0, 1'b0);
        load64("ld_d10_cleared", 2'd3, 1'b0, 64'h10, 64'd0, 1'b0);

        // 32-bit instance (swept alongside the reset above)
        req32("b_size3_load", 1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        req32("b_st_word4", 1'b1, 2'd2, 1'b0, 32'h4, 32'h80001234, 32'h0, 1'b0);
        req32("b_ld_h6_s", 1'b0, 2'd1, 1'b0, 32'h6, 32'h0, 32'hFFFF8000, 1'b0);
        req32("b_ld_w4", 1'b0, 2'd2, 1'b0, 32'h4, 32'h0, 32'h80001234, 1'b0);
        req32("b_ld_b7_u", 1'b0, 2'd0, 1'b1, 32'h7, 32'h0, 32'h00000080, 1'b0);
        req32("b_size3_store", 1'b1, 2'd3, 1'b0, 32'h8, 32'hFFFFFFFF, 32'h0, 1'b1);
        req32("b_ld_w8_untouched", 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 32'h0, 1'b0);
        req32("b_ld_w40_range", 1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_mem_sized.md
# data_mem_sized

Parametrised byte-addressed, little-endian data memory for the CPU load/store stage. It replaces the fixed 64-bit, combinational-read, tri-state data memory. It adds:
- sized accesses (byte, half, word, double) with sign or zero extension on loads;
- a valid/ready request-response handshake with a registered response;
- alignment and range error reporting;
- a post-reset clear sweep, so reset no longer clears the whole array in one cycle.

## Interface
Parameters:
- XLEN, 64, data width in bits; legal values 32 or 64; BYTES = XLEN/8
- DEPTH_BYTES, 8192, memory size in bytes; must be a multiple of BYTES
- ADDR_W, 64, request address width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = double
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  ADDR_W  byte address
- req_wdata  in  XLEN  store data; low (1<<req_size) bytes used
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_rdata  out  XLEN  load result, extended to XLEN; 0 for stores and errors
- rsp_err  out  1  request was misaligned, out of range or an illegal size

## Operation
- **State machine:** INIT, IDLE, RESP.
- **INIT:**
  - Entered on rst; held while rst = 1 with clear counter = 0.
  - After rst falls, one BYTES-wide row is written to 0 per cycle, for DEPTH_BYTES/BYTES cycles.
  - After the last row is cleared, the block moves to IDLE.
  - req_ready = 0 throughout INIT.
- **IDLE:**
  - req_ready = 1.
  - On req_valid && req_ready, the request is accepted and the block moves to RESP.
- **RESP:**
  - rsp_valid = 1 and req_ready = 0.
  - When rsp_ready = 1, the block returns to IDLE. There is no back-to-back acceptance in the same cycle.
- **Access size:** n = 1 << req_size bytes.
- **Error conditions** (rsp_err = 1) are any of:
  - req_addr mod n != 0;
  - req_addr + n > DEPTH_BYTES, evaluated at ADDR_W+1 bits so it cannot wrap;
  - req_size = 3 when XLEN = 32.
- **On error:** no memory byte changes and rsp_rdata = 0.
- **Store:** bytes addr..addr+n-1 receive req_wdata[8k+7:8k] for k = 0..n-1. All other bytes are unchanged.
- **Load:** result = {mem[addr+n-1], ..., mem[addr]}. It is sign- or zero-extended from 8n bits to XLEN according to req_unsigned. When n = BYTES, no extension is applied.
- **Reset mid-operation:**
  - An in-flight response is discarded.
  - The block returns to INIT and the full clear sweep repeats.
  - Stores that committed before reset are erased by the sweep.

## Timing
- **Reset values:** req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, state = INIT.
- **Clear sweep length:** DEPTH_BYTES/BYTES cycles after the first rising edge with rst = 0. req_ready rises on the edge that completes the last row (8192/8 = 1024 cycles at the defaults).
- **Store commit:** on the accepting edge.
- **Load data:** sampled from the array on the accepting edge and registered into rsp_rdata.
- **Latency:**
  - rsp_valid rises on the accepting edge, so it is visible 1 cycle after acceptance.
  - rsp_rdata and rsp_err are stable while rsp_valid = 1.
- **Back-pressure:** rsp_valid stays 1 and rsp_rdata/rsp_err are held until the edge where rsp_ready = 1. rsp_valid falls on that edge.
- **Throughput:** one request per 2 cycles at most, when rsp_ready is held at 1.
- **Output quality:** outputs are never driven X or Z. rsp_rdata and rsp_err keep their last values when rsp_valid = 0.
- **Ignored requests:** req_valid during INIT or RESP has no effect. The requester must hold its request until req_ready is seen high.

## Test plan
- **Reset sweep:** pulse rst for 3 cycles at defaults.
  - req_ready stays 0 for exactly 1024 cycles after rst falls, then goes to 1.
  - A double load at 0x1FF8 then returns 0, err 0.
- **Sized stores and loads:** store double 0x0C3C3EAAF00FCC33 at 0x10, then load:
  - byte 0x10 signed → 0x0000000000000033;
  - byte 0x13 signed → 0xFFFFFFFFFFFFFFF0;
  - half 0x12 unsigned → 0x000000000000F00F;
  - word 0x14 signed → 0x000000000C3C3EAA.
- **Partial store:** store half 0xBEEF at 0x12 over the previous data, then load double 0x10 → 0x0C3C3EAABEEFCC33.
- **Errors:**
  - Misaligned word store at 0x21 → rsp_err = 1; a following double load at 0x20 is unchanged.
  - Double load at 0x1FFC → err 1, rdata 0.
  - With XLEN = 32, size 3 → err 1.
- **Back-pressure:** hold rsp_ready = 0 for 5 cycles after a load.
  - rsp_valid and rsp_rdata are stable for 5 cycles and req_ready = 0.
  - A second req_valid in that window is not accepted.
  - rsp_ready = 1 → rsp_valid drops and req_ready returns 1 the next cycle.
- **Reset mid-response:** assert rst while in RESP.
  - rsp_valid goes to 0 on the next edge and INIT restarts.
  - The earlier stored data reads back as 0 after the sweep.
